// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - round-robin arbiter sharing the register file write port
module regwr_arbiter #(
   parameter int WIDTH    = 64,
   parameter int AW       = 5,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             req0_valid,
   input  logic [AW-1:0]    req0_addr,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [AW-1:0]    req1_addr,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [WIDTH-1:0] wr_data,
   output logic             wr_src
);

   localparam logic [AW-1:0] ZR_ADDR = AW'(ZERO_REG);

   // index of the most recently granted requester; the other one wins a tie
   logic last;

   logic             gnt0;
   logic             gnt1;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_data;

   // grant depends only on valids, stall, reset and the pointer
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && !stall) begin
         gnt0 = req0_valid && (!req1_valid || last);
         gnt1 = req1_valid && (!req0_valid || !last);
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // mux the winning requester's payload toward the write port register
   always_comb begin
      sel_addr = req0_addr;
      sel_data = req0_data;
      if (gnt1) begin
         sel_addr = req1_addr;
         sel_data = req1_data;
      end
   end

   // register the write port and advance the pointer on every transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last    <= 1'b1;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_src  <= 1'b0;
      end else if (gnt0 || gnt1) begin
         last    <= gnt1;
         wr_src  <= gnt1;
         wr_addr <= sel_addr;
         wr_data <= sel_data;
         // writes to the zero register are consumed but never reach the file
         wr_en   <= (sel_addr != ZR_ADDR);
      end else begin
         wr_en   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - self-checking bench for regwr_arbiter
module tb_regwr_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [63:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [63:0] req1_data;
   logic        req1_ready;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        wr_src;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_last;
   bit          m_en;
   logic [4:0]  m_addr;
   logic [63:0] m_data;
   int          m_src;

   always #5 clk = ~clk;

   regwr_arbiter #(.WIDTH(64), .AW(5), .ZERO_REG(31)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
   );

   task automatic model_reset();
      m_last = 1; m_en = 0; m_addr = '0; m_data = '0; m_src = 0;
   endtask

   // who should be granted given the current inputs: -1 means nobody
   function automatic int model_grant();
      int g;
      g = -1;
      if (reset !== 1'b1 && stall !== 1'b1) begin
         if (req0_valid && req1_valid) g = 1 - m_last;
         else if (req0_valid)          g = 0;
         else if (req1_valid)          g = 1;
      end
      return g;
   endfunction

   task automatic drive(input bit v0, input logic [4:0] a0, input logic [63:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [63:0] d1,
                        input bit st);
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      stall = st;
      #1;
   endtask

   task automatic tick(output int g);
      g = model_grant();
      @(posedge clk);
      if (g == 0) begin
         m_last = 0; m_src = 0; m_addr = req0_addr; m_data = req0_data; m_en = (req0_addr != 5'd31);
      end else if (g == 1) begin
         m_last = 1; m_src = 1; m_addr = req1_addr; m_data = req1_data; m_en = (req1_addr != 5'd31);
      end else begin
         m_en = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      int g;
      reset = 1'b1; stall = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'h0123456789ABCDEF;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick(g);
         n_checks++;
         if (req0_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0 || wr_src !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready0=%b en=%b addr=%0d data=%h src=%b, required all zero",
                     req0_ready, wr_en, wr_addr, wr_data, wr_src);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release_ready: got %b required 1", req0_ready);
      end
      tick(g);
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'h0123456789ABCDEF || wr_src !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_first_write: en=%b addr=%0d data=%h src=%b, required 1/5/0123456789abcdef/0",
                  wr_en, wr_addr, wr_data, wr_src);
      end
   endtask

   task automatic test_contention();
      int g;
      // a lone requester-1 write leaves the pointer at 1, so requester 0 leads
      drive(0, 0, 0, 1, 5'd9, 64'h9, 0);
      tick(g);
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'd1, 64'h1111111111111111, 1, 5'd2, 64'h2222222222222222, 0);
         n_checks++;
         if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL contention_grant[%0d]: ready0=%b ready1=%b, required %b %b",
                     i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
         end
         tick(g);
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2) || wr_src !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL contention_write[%0d]: en=%b addr=%0d src=%b, required 1/%0d/%0d",
                     i, wr_en, wr_addr, wr_src, (i % 2 == 0) ? 1 : 2, i % 2);
         end
      end
   endtask

   task automatic test_xzr_drop();
      int g;
      drive(0, 0, 0, 1, 5'd31, 64'hFFFFFFFFFFFFFFFF, 0);
      n_checks++;
      if (req1_ready !== 1'b1) begin
         n_fail++; $display("FAIL xzr_ready: got %b required 1", req1_ready);
      end
      tick(g);
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd31 || wr_data !== 64'hFFFFFFFFFFFFFFFF || wr_src !== 1'b1) begin
         n_fail++;
         $display("FAIL xzr_write: en=%b addr=%0d data=%h src=%b, required 0/31/ffffffffffffffff/1",
                  wr_en, wr_addr, wr_data, wr_src);
      end
      drive(1, 5'd4, 64'h44, 1, 5'd6, 64'h66, 0);
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL xzr_pointer: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
      end
      tick(g);
   endtask

   task automatic test_stall();
      int g;
      // pointer is 0 here, so requester 1 is next in line after the stall
      for (int i = 0; i < 2; i++) begin
         drive(1, 5'd8, 64'h88, 1, 5'd10, 64'hAA, 1);
         n_checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready[%0d]: ready0=%b ready1=%b, required 0 0", i, req0_ready, req1_ready);
         end
         tick(g);
         n_checks++;
         if (wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stall_wr_en[%0d]: got %b required 0", i, wr_en);
         end
      end
      drive(1, 5'd8, 64'h88, 1, 5'd10, 64'hAA, 0);
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: ready0=%b ready1=%b, required 0 1", req0_ready, req1_ready);
      end
      tick(g);
      n_checks++;
      if (wr_en !== 1'b1 || wr_addr !== 5'd10 || wr_src !== 1'b1) begin
         n_fail++; $display("FAIL stall_write: en=%b addr=%0d src=%b, required 1/10/1", wr_en, wr_addr, wr_src);
      end
   endtask

   task automatic test_async_reset();
      int g;
      for (int i = 0; i < 2; i++) begin
         drive(1, 5'd12, 64'hC0FFEE, 1, 5'd13, 64'hBEEF, 0);
         tick(g);
      end
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0 || wr_src !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: en=%b addr=%0d data=%h src=%b r0=%b r1=%b, required all zero",
                  wr_en, wr_addr, wr_data, wr_src, req0_ready, req1_ready);
      end
      tick(g);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_fail++; $display("FAIL async_reset_pointer: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
      end
      tick(g);
      n_checks++;
      if (wr_en !== 1'b1 || wr_src !== 1'b0 || wr_addr !== 5'd12) begin
         n_fail++; $display("FAIL async_reset_write: en=%b src=%b addr=%0d, required 1/0/12", wr_en, wr_src, wr_addr);
      end
   endtask

   task automatic test_streaming();
      int g;
      logic [63:0] d;
      for (int i = 0; i < 5; i++) begin
         d = {$urandom, $urandom};
         drive(0, 0, 0, 1, 5'(3 + i), d, 0);
         n_checks++;
         if (req1_ready !== 1'b1) begin
            n_fail++; $display("FAIL stream_ready[%0d]: got %b required 1", i, req1_ready);
         end
         tick(g);
         n_checks++;
         if (wr_en !== 1'b1 || wr_addr !== 5'(3 + i) || wr_data !== d || wr_src !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_write[%0d]: en=%b addr=%0d data=%h src=%b, required 1/%0d/%h/1",
                     i, wr_en, wr_addr, wr_data, wr_src, 3 + i, d);
         end
      end
   endtask

   task automatic test_random();
      int g;
      bit p0, p1;
      logic [4:0]  a0, a1;
      logic [63:0] d0, d1;
      p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && ($urandom % 3 != 0)) begin p0 = 1; a0 = 5'($urandom); d0 = {$urandom, $urandom}; end
         if (!p1 && ($urandom % 3 != 0)) begin p1 = 1; a1 = 5'($urandom); d1 = {$urandom, $urandom}; end
         drive(p0, a0, d0, p1, a1, d1, ($urandom % 5 == 0));
         g = model_grant();
         n_checks++;
         if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
            n_fail++;
            $display("FAIL random_grant[%0d]: ready0=%b ready1=%b, required %b %b", i, req0_ready, req1_ready, (g == 0), (g == 1));
         end
         tick(g);
         if (g == 0) p0 = 0;
         if (g == 1) p1 = 0;
         n_checks++;
         if (wr_en !== m_en || (m_en && (wr_addr !== m_addr || wr_data !== m_data || wr_src !== 1'(m_src)))) begin
            n_fail++;
            $display("FAIL random_write[%0d]: en=%b addr=%0d data=%h src=%b, required %b/%0d/%h/%0d",
                     i, wr_en, wr_addr, wr_data, wr_src, m_en, m_addr, m_data, m_src);
         end
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_xzr_drop();
      test_stall();
      test_async_reset();
      test_streaming();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
